// File: rtl/grf_mp.sv
// ---------------------------------------------------------------------------
// grf_mp : multi-port general register file
//
// - NR combinational read ports with write-through bypass
// - two write ports (port 1 wins on an address collision)
// - per-register pending-write scoreboard (set at decode, cleared at writeback)
// - ZERO_REG = 1 hardwires register 0 to zero and keeps it permanently not busy
//
// Optional build macro: GRF_TRACE_EN
//   When defined, every enabled write port prints a trace line on each clock
//   edge outside reset ("@<pc>: $<addr> <= <data>"), port 0 before port 1.
//   When undefined, the block is silent and fully synthesisable.
// ---------------------------------------------------------------------------
module grf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 grf_clk,
    input  logic                 grf_reset,
    input  logic [NR*AW-1:0]     grf_raddr,
    output logic [NR*DW-1:0]     grf_rdata,
    output logic [NR-1:0]        grf_rbusy,
    input  logic                 grf_we0,
    input  logic [AW-1:0]        grf_waddr0,
    input  logic [DW-1:0]        grf_wdata0,
    input  logic [31:0]          grf_pc0,
    input  logic                 grf_we1,
    input  logic [AW-1:0]        grf_waddr1,
    input  logic [DW-1:0]        grf_wdata1,
    input  logic [31:0]          grf_pc1,
    input  logic                 grf_bset,
    input  logic [AW-1:0]        grf_baddr,
    output logic [(2**AW)-1:0]   grf_busy
);

    localparam int NREG = 2 ** AW;

    // Register storage and scoreboard state
    logic [DW-1:0]   regs_r [NREG];
    logic [NREG-1:0] busy_r;

    // Write qualification (address-0 drop when the zero register is enabled)
    logic            zero_en_s;
    logic            wr0_ok_s;
    logic            wr1_ok_s;
    logic            bset_ok_s;

    // Scoreboard next-state helpers
    logic [NREG-1:0] one_hot_base_s;
    logic [NREG-1:0] clr_vec_s;
    logic [NREG-1:0] set_vec_s;
    logic [NREG-1:0] busy_next_s;

    // Per-read-port decode
    logic [AW-1:0]   rd_addr_s [NR];
    logic [DW-1:0]   rd_data_s [NR];
    logic            rd_byp_s  [NR];

    // Qualify writes and scoreboard sets against the hardwired zero register
    always_comb begin
        zero_en_s = (ZERO_REG != 0);
        wr0_ok_s  = grf_we0 && !(zero_en_s && (grf_waddr0 == {AW{1'b0}}));
        wr1_ok_s  = grf_we1 && !(zero_en_s && (grf_waddr1 == {AW{1'b0}}));
        bset_ok_s = grf_bset && !(zero_en_s && (grf_baddr == {AW{1'b0}}));
    end

    // Build scoreboard set/clear masks; a same-cycle set overrides a clear
    always_comb begin
        one_hot_base_s = {{(NREG-1){1'b0}}, 1'b1};
        clr_vec_s      = {NREG{1'b0}};
        set_vec_s      = {NREG{1'b0}};
        if (grf_we0) begin
            clr_vec_s = clr_vec_s | (one_hot_base_s << grf_waddr0);
        end else begin
            clr_vec_s = clr_vec_s;
        end
        if (grf_we1) begin
            clr_vec_s = clr_vec_s | (one_hot_base_s << grf_waddr1);
        end else begin
            clr_vec_s = clr_vec_s;
        end
        if (bset_ok_s) begin
            set_vec_s = one_hot_base_s << grf_baddr;
        end else begin
            set_vec_s = {NREG{1'b0}};
        end
        busy_next_s = set_vec_s | (busy_r & ~clr_vec_s);
    end

    // Register file storage; port 1 is applied last so it wins a collision
    always_ff @(posedge grf_clk or posedge grf_reset) begin
        if (grf_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (wr0_ok_s) begin
                regs_r[grf_waddr0] <= grf_wdata0;
            end
            if (wr1_ok_s) begin
                regs_r[grf_waddr1] <= grf_wdata1;
            end
        end
    end

    // Pending-write scoreboard
    always_ff @(posedge grf_clk or posedge grf_reset) begin
        if (grf_reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Read ports: zero register, then port 1 bypass, port 0 bypass, storage
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            rd_addr_s[k] = grf_raddr[k*AW +: AW];
            rd_data_s[k] = regs_r[rd_addr_s[k]];
            rd_byp_s[k]  = 1'b0;
            if (grf_reset) begin
                rd_data_s[k] = {DW{1'b0}};
                rd_byp_s[k]  = 1'b0;
            end else if (zero_en_s && (rd_addr_s[k] == {AW{1'b0}})) begin
                rd_data_s[k] = {DW{1'b0}};
                rd_byp_s[k]  = 1'b0;
            end else if (grf_we1 && (grf_waddr1 == rd_addr_s[k])) begin
                rd_data_s[k] = grf_wdata1;
                rd_byp_s[k]  = 1'b1;
            end else if (grf_we0 && (grf_waddr0 == rd_addr_s[k])) begin
                rd_data_s[k] = grf_wdata0;
                rd_byp_s[k]  = 1'b1;
            end else begin
                rd_data_s[k] = regs_r[rd_addr_s[k]];
                rd_byp_s[k]  = 1'b0;
            end
        end
    end

    // Pack read data and busy flags; bypassed data is available, so not busy
    always_comb begin
        grf_rdata = {(NR*DW){1'b0}};
        grf_rbusy = {NR{1'b0}};
        for (int k = 0; k < NR; k++) begin
            grf_rdata[k*DW +: DW] = rd_data_s[k];
            grf_rbusy[k]          = busy_r[rd_addr_s[k]] & ~rd_byp_s[k];
        end
    end

    assign grf_busy = busy_r;

`ifdef GRF_TRACE_EN
    // Write trace: every enabled port is logged, even dropped/overridden writes
    always @(posedge grf_clk) begin
        if (!grf_reset) begin
            if (grf_we0) begin
                $display("@%h: $%d <= %h", grf_pc0, grf_waddr0, grf_wdata0);
            end
            if (grf_we1) begin
                $display("@%h: $%d <= %h", grf_pc1, grf_waddr1, grf_wdata1);
            end
        end
    end
`else
    // PCs only feed the trace; fold them so they are not left dangling
    logic trace_unused;
    assign trace_unused = ^{grf_pc0, grf_pc1};
`endif

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, two-read GRF.
- Provides NR combinational read ports and two write ports with write-through bypass.
- Includes a per-register pending-write scoreboard, so the pipelined datapath can detect RAW hazards locally.
- Sits in decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; register count is 2**AW.
- NR, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never marked busy.

Ports:
- grf_clk  input  1  rising-edge clock.
- grf_reset  input  1  asynchronous, active-high reset.
- grf_raddr  input  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- grf_rdata  output  NR*DW  read data; port k uses bits [k*DW +: DW].
- grf_rbusy  output  NR  port k's addressed register has a pending write.
- grf_we0  input  1  write enable, port 0.
- grf_waddr0  input  AW  write address, port 0.
- grf_wdata0  input  DW  write data, port 0.
- grf_pc0  input  32  PC of the instruction writing through port 0 (trace only).
- grf_we1  input  1  write enable, port 1.
- grf_waddr1  input  AW  write address, port 1.
- grf_wdata1  input  DW  write data, port 1.
- grf_pc1  input  32  PC of the instruction writing through port 1 (trace only).
- grf_bset  input  1  mark a register busy (issue of a producer).
- grf_baddr  input  AW  register to mark busy.
- grf_busy  output  2**AW  full scoreboard vector, for debug.

Behaviour:
- Reset: asynchronous, active-high. Immediately clears all registers and all busy bits to 0. Outputs then read 0, grf_rbusy = 0 and grf_busy = 0. Reset dominates any same-cycle write or set.
- Writes:
  - Committed on the rising grf_clk edge when grf_weN = 1.
  - If ZERO_REG = 1, a write to address 0 is dropped.
  - If both ports write the same address in one cycle, port 1 wins.
- Reads:
  - Combinational, zero latency.
  - Bypass priority within a cycle: port 1 write > port 0 write > stored value.
  - Bypass applies only when weN = 1 and waddrN = raddr.
  - Bypass is suppressed for address 0 when ZERO_REG = 1; that read returns 0.
- Scoreboard, updated at the clock edge:
  - A write on either port clears busy[waddrN].
  - grf_bset = 1 sets busy[grf_baddr].
  - If set and clear target the same register in one cycle, set wins: the new producer supersedes the old one.
  - If ZERO_REG = 1, busy[0] is never set.
- grf_rbusy[k]:
  - Equals busy[raddr_k], masked to 0 when a same-cycle write to that address is bypassed (data is available now).
  - A same-cycle grf_bset to that address is not reflected until the next cycle.
- Setting an already-busy register leaves it busy; no counting, so the single-outstanding-producer rule is the pipeline's responsibility.
- Clearing a non-busy register is legal and has no effect.
- Reset mid-operation: all pending busy bits are lost; writes issued in the reset cycle have no effect.

Optional Feature:
- Macro: GRF_TRACE_EN.
- Defined:
  - On each clock edge where grf_weN = 1 and reset is low, print "@%h: $%d <= %h" with grf_pcN, grf_waddrN and grf_wdataN.
  - Port 0 prints before port 1.
  - A write is printed even when it is dropped (address 0) or overridden by a port collision, matching the grader's expected log format.
- Undefined: no simulation output. Functionally identical otherwise, and synthesisable.

Test Plan:
- Reset then read -> assert grf_reset while registers hold data -> all 32 grf_rdata = 0 and grf_busy = 0 immediately, without waiting for a clock edge.
- Write then read -> we0 = 1, waddr0 = 5, wdata0 = 0x12345678 -> read port 0 on addr 5 returns 0x12345678 in the same cycle (bypass) and on every later cycle (stored).
- Zero register -> we1 = 1, waddr1 = 0, wdata1 = 0xFFFFFFFF, with bset on addr 0 -> reads of addr 0 return 0; busy[0] = 0.
- Write collision -> both ports write addr 7, port 0 data 0xAAAA0000 and port 1 data 0x0000BBBB -> same-cycle read = 0x0000BBBB; next-cycle read = 0x0000BBBB.
- Scoreboard sequence -> bset on addr 9 at cycle 1, then rbusy for addr 9 = 1 at cycle 2. At cycle 3, write addr 9 = 0x55 -> rbusy = 0 in cycle 3 (bypass mask) and busy[9] = 0 from cycle 4.
- Set/clear race -> bset on addr 3 in the same cycle as we0 writing addr 3 -> busy[3] = 1 after the edge; register 3 holds the written data.
